keypad_scanner: RTL
===================

# keypad_scanner

Scans a 4x4 matrix keypad and delivers debounced key presses to the processor side of the FPGA top level. It drives one keypad column low at a time and reads the four rows back, which makes it the input-side counterpart of the multiplexed 7-segment driver. Each accepted press is held in a code register with a valid/ack handshake, so the MIPS system can poll it through a GPI word. The block also flags presses that arrive before the previous one is acknowledged.

## Interface
- SCAN_DIV, 5000: clk cycles each column is driven (dwell); must be ≥ 4.
- DEBOUNCE_SCANS, 3: consecutive full scans needed to accept a press or a release; must be ≥ 2.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- row  in  4  keypad rows, active-low with external pull-ups; asynchronous to clk.
- col  out  4  keypad column drive, active-low one-hot.
- key_code  out  4  code of the last accepted key, = row_index*4 + col_index.
- key_valid  out  1  high while key_code holds an unacknowledged press.
- key_ack  in  1  one-cycle pulse from the consumer; clears key_valid and overrun.
- key_down  out  1  high while the accepted key is still physically held.
- overrun  out  1  sticky flag: a press was accepted while key_valid was already high.

## Operation
- Row input path:
  - row passes through a 2-flop synchronizer.
  - The synchronized row is sampled on the last cycle of each dwell (divider terminal count).
- Column scanning:
  - Divider counts 0..SCAN_DIV-1.
  - On terminal count, col_index advances 0→1→2→3→0.
  - col = ~(4'b0001 << col_index).
- Scan result:
  - Samples accumulate into a 16-bit snapshot.
  - At the terminal count with col_index==3 (scan end), the snapshot is classified as NONE, SINGLE(code) or MULTI.
  - MULTI is treated as NONE for acceptance purposes, but it does not count as a release.
- FSM, evaluated only at scan end:
  - IDLE: SINGLE(c) → DEBOUNCE, cand=c, cnt=1. Otherwise stay.
  - DEBOUNCE:
    - SINGLE(cand): cnt+1; if cnt+1==DEBOUNCE_SCANS → PRESSED and accept cand.
    - SINGLE(other) → restart with cand=other, cnt=1.
    - NONE/MULTI → IDLE.
  - PRESSED:
    - NONE → RELEASE_DB, cnt=1.
    - SINGLE/MULTI → stay.
  - RELEASE_DB:
    - NONE: cnt+1; if cnt+1==DEBOUNCE_SCANS → IDLE.
    - Any key → PRESSED, with no new accept.
- Accept (DEBOUNCE→PRESSED):
  - If key_valid==0 or key_ack is high in the same cycle: key_code←cand, key_valid←1.
  - If key_valid==1 and key_ack is low: key_code is unchanged and overrun←1.
- key_ack without a simultaneous accept: key_valid←0, overrun←0.
- key_ack while key_valid==0 has no effect.
- key_down = (state==PRESSED || state==RELEASE_DB).

## Timing
- Reset values:
  - col=4'b1110.
  - key_code=0, key_valid=0, key_down=0, overrun=0.
  - state=IDLE, divider=0, col_index=0, snapshot=0.
- A row change reaches the sampler 2 cycles after it appears on the pins.
- One full scan = 4*SCAN_DIV cycles.
- key_valid, key_code and key_down update on the scan-end clock edge itself; they are visible in the following cycle.
- Press-to-valid latency: DEBOUNCE_SCANS scan ends from the first scan whose sample sees the key (upper bound DEBOUNCE_SCANS+1 scans).
- key_valid falls on the edge where key_ack is sampled high, with one-cycle latency.
- Reset mid-scan or mid-debounce aborts immediately. No partial press survives.

## Structure
- Shared header keypad_defs.vh holds:
  - FSM state encodings (IDLE, DEBOUNCE, PRESSED, RELEASE_DB, 2 bits).
  - NUM_ROWS=4, NUM_COLS=4, KEY_CODE_W=4.
- The one natural sub-module is sync2, a 4-bit two-flop synchronizer for row.
  - It is reusable for the switch inputs elsewhere in the top level.
- The divider, snapshot/classifier, FSM and output register remain in keypad_scanner.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, giving a 16-cycle scan.
- Reset, no keys:
  - col steps 1110→1101 at cycle 4 → 1011 → 0111 → 1110 at cycle 16.
  - All outputs stay 0.
- Single press:
  - Pull row[2] low whenever col[1]==0, for 5 scans.
  - key_valid=1 and key_code=4'h9 after the 3rd scan end; key_down=1.
  - key_ack pulse → key_valid=0 the next cycle.
  - Release → key_down=0 after 3 empty scans.
- Bounce:
  - Key 9 for 2 scans, absent 1 scan, then present 3 scans.
  - No key_valid until the end of the final 3rd consecutive scan.
- Multiple keys:
  - Keys 0 and F held together for 6 scans → key_valid stays 0, key_down stays 0.
- Overrun:
  - Accept key 5 with no ack, release for 3 scans, accept key A.
  - key_code stays 5 and overrun=1.
  - key_ack clears both.
  - An ack coincident with the accept of key A instead loads A with no overrun.
- Reset mid-DEBOUNCE:
  - Assert rst after 2 scans of key 3 → immediate reset values.
  - After rst is released, 3 fresh scans are needed before key_valid rises.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM encodings,
// scan classification and the helper that reduces a snapshot to a result.
package keypad_scanner_pkg;

  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;
  localparam int KEY_CODE_W = 4;
  localparam int NUM_KEYS   = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DEBOUNCE   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_e;

  typedef struct packed {
    scan_kind_e            kind;
    logic [KEY_CODE_W-1:0] code;
  } scan_result_t;

  // Snapshot bit index equals row_index*NUM_COLS + col_index, i.e. the key code.
  function automatic scan_result_t classify(input logic [NUM_KEYS-1:0] snap);
    scan_result_t res;
    int unsigned  hits;
    hits     = 0;
    res.kind = SCAN_NONE;
    res.code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (snap[i]) begin
        hits++;
        res.code = KEY_CODE_W'(i);
      end
    end
    if (hits == 1) begin
      res.kind = SCAN_SINGLE;
    end else if (hits > 1) begin
      res.kind = SCAN_MULTI;
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-press handshake between the scanner and its consumer.
// key_valid rises with key_code stable; it stays high until the consumer
// pulses key_ack for one cycle, which clears key_valid and overrun on that edge.
interface keypad_scanner_if;
  import keypad_scanner_pkg::*;

  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_ack;
  logic                  key_down;
  logic                  overrun;

  modport master (
    output key_code,
    output key_valid,
    output key_down,
    output overrun,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_down,
    input  overrun,
    output key_ack
  );

endinterface

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous levels
// (keypad rows, slide switches).
module keypad_scanner_sync2 #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, scan-level
// debounce FSM and a held key-code register with valid/ack and overrun.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_ROWS-1:0]   row,
  output logic [NUM_COLS-1:0]   col,
  keypad_scanner_if.master      kif,
  output kp_state_e             state_dbg
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [NUM_ROWS-1:0]   row_sync;

  logic [DIV_W-1:0]      div_q, div_d;
  logic [1:0]            col_idx_q, col_idx_d;
  logic [NUM_KEYS-1:0]   snap_q, snap_d;
  kp_state_e             state_q, state_d;
  logic [KEY_CODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  logic                  tc;
  logic                  scan_end;
  logic                  accept;
  logic [CNT_W-1:0]      cnt_inc;
  scan_result_t          scan_res;

  keypad_scanner_sync2 #(
    .W       (NUM_ROWS),
    .RST_VAL ({NUM_ROWS{1'b1}})
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_sync)
  );

  assign tc       = (div_q == DIV_W'(SCAN_DIV - 1));
  assign scan_end = tc && (col_idx_q == 2'd3);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Divider, column index and snapshot; the last column's sample is folded
  // into snap_d so the classifier sees the complete scan on the scan-end edge.
  always_comb begin
    div_d     = tc ? '0 : div_q + DIV_W'(1);
    col_idx_d = tc ? col_idx_q + 2'd1 : col_idx_q;
    snap_d    = snap_q;
    if (tc) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        snap_d[{2'(r), col_idx_q}] = ~row_sync[r];
      end
    end
  end

  assign scan_res = classify(snap_d);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (scan_end) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_res.kind == SCAN_SINGLE) begin
            state_d = ST_DEBOUNCE;
            cand_d  = scan_res.code;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (scan_res.kind == SCAN_SINGLE && scan_res.code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
              state_d = ST_PRESSED;
              accept  = 1'b1;
            end
          end else if (scan_res.kind == SCAN_SINGLE) begin
            cand_d = scan_res.code;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          // A multi-key scan keeps the held key alive; only an empty scan releases.
          if (scan_res.kind == SCAN_NONE) begin
            state_d = ST_RELEASE_DB;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_RELEASE_DB: begin
          if (scan_res.kind == SCAN_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_PRESSED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // An ack on the accept edge frees the register so the new code loads cleanly.
  always_comb begin
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (kif.key_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (accept) begin
      if (valid_q && !kif.key_ack) begin
        overrun_d = 1'b1;
      end else begin
        code_d  = cand_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      col_idx_q <= 2'd0;
      snap_q    <= '0;
      state_q   <= ST_IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      snap_q    <= snap_d;
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign col           = ~(4'b0001 << col_idx_q);
  assign kif.key_code  = code_q;
  assign kif.key_valid = valid_q;
  assign kif.overrun   = overrun_q;
  assign kif.key_down  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_DB);
  assign state_dbg     = state_q;

endmodule
